exu_cal: RTL and testbench
==========================

# exu_cal

Calculation center of the cirno9 execute stage; the responder end of the ALU-to-cal handshake. It accepts a decoded operation bundle (one-hot op flags plus two 33-bit extended operands) and returns a 32-bit result. ADD, SUB, XOR and CMP complete in the request cycle. SLL, SRL and SRA use an iterative one-bit-per-cycle shifter with a small FSM, so the ALU stalls until ready is asserted.

## Interface
Parameters:
- None. Widths come from `cirno9_define.v` (`CIRNO_CAL_OPB_SIZE` and the `CIRNO_CAL_*` field macros).

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `hs_al4cal_val`  in  1  request valid from ALU; held high until ready.
- `i_cal_opb`  in  `CIRNO_CAL_OPB_SIZE`  op bundle:
  - one-hot flags ADD/SUB/SLL/SRL/SRA/XOR/CMP;
  - OPN1 and OPN2, each 33 bits, already sign- or zero-extended by the ALU.
- `hs_cal4al_rdy`  out  1  request completes this cycle; `o_cal_res` is valid.
- `o_cal_res`  out  32  result; 0 whenever `hs_cal4al_rdy`=0.

## Operation
- Operands: `a` = OPN1[32:0], `b` = OPN2[32:0]; `shamt` = b[4:0].
- Combinational ops, evaluated only in IDLE; ready is asserted in the same cycle as val:
  - ADD: (a+b)[31:0].
  - SUB: (a−b)[31:0].
  - XOR: (a^b)[31:0].
  - CMP: 34-bit difference {a[32],a} − {b[32],b}. Result {31'b0, diff[33]}, i.e. 1 iff a<b as signed 33-bit. This covers both SLT and SLTU, because the extension choice is made upstream.
- Shift ops use a 33-bit shift register `sh` and a 5-bit counter `cnt`.
  - SLL shifts left and fills 0.
  - SRL/SRA shift right and fill with sh[32]. Because SRL operands arrive zero-extended, one arithmetic right shifter serves both.
- FSM states:
  - IDLE:
    - val & shift op & shamt==0: rdy=1, res=a[31:0]; stay in IDLE.
    - val & shift op & shamt≠0: load sh=a, cnt=shamt; go to BUSY; rdy=0.
    - Otherwise stay in IDLE.
  - BUSY: shift sh by 1 and decrement cnt each cycle. Go to DONE when the cycle's shift is made with cnt==1.
  - DONE: rdy=1, res=sh[31:0]; go to IDLE next cycle.
- Abort: in BUSY or DONE, if val==0 or no shift flag is set, go to IDLE next cycle with rdy=0. This is the flush path, since the ALU zero-gates the bundle when val drops.
- val high with no op flag set: rdy=0, res=0, state unchanged.
- More than one op flag set is illegal. Result is unspecified; the bench does not check it.
- Shift direction and kind are re-read from the live bundle in every BUSY/DONE cycle. The ALU holds the bundle stable, so no op is latched.

## Timing
- Reset (async, immediate):
  - state=IDLE, sh=0, cnt=0.
  - `hs_cal4al_rdy`=0, `o_cal_res`=0.
- Rdy and res are combinational from state plus inputs in IDLE, and from registers in DONE.
- No outputs are registered beyond the FSM state, sh and cnt.
- Latency, counted from the first val cycle:
  - ADD/SUB/XOR/CMP: 0 cycles (rdy in the same cycle).
  - Shift with shamt=0: 0 cycles.
  - Shift with shamt=N>0: rdy at cycle N+1 (load, N BUSY cycles, then DONE).
- Maximum latency is 32 cycles (N=31).
- Back-to-back requests:
  - Combinational ops can complete every cycle.
  - After DONE, the next request is accepted in IDLE one cycle later.
  - The ALU must see rdy for exactly one cycle per request.
- Reset asserted mid-shift: FSM returns to IDLE immediately and rdy falls in the same cycle.

## Test plan
- ADD: a=0x0_7FFFFFFF, b=0x0_00000001, val=1 → same-cycle rdy=1, res=0x80000000. SUB 5−7 → res=0xFFFFFFFE.
- CMP:
  - Signed: a=sext(0xFFFFFFFF), b=sext(1) → res=1.
  - Unsigned: a=zext(0xFFFFFFFF), b=zext(1) → res=0.
  - Equal operands → res=0.
- SRA: a=sext(0x80000000), shamt=4, val held → rdy low for 4 cycles, then high on cycle 5 with res=0xF8000000. IDLE on cycle 6.
- SRL: a=zext(0x80000000), shamt=31 → rdy on cycle 32, res=0x00000001. SLL a=1, shamt=0 → same-cycle res=1.
- Abort: start SLL shamt=8, drop val on cycle 3 → rdy never asserted and state is IDLE on cycle 4. A following XOR 0xF0^0xFF completes same-cycle with res=0x0F.
- Reset mid-shift: assert rst during BUSY → rdy=0 and res=0 immediately. After release, an ADD 2+3 returns 5 same-cycle.

Source files
------------

// File: rtl/exu_cal.sv
// exu_cal - calculation center of the cirno9 execute stage.
//
// Responder end of the ALU-to-cal handshake. ADD, SUB, XOR and CMP finish
// in the request cycle. SLL, SRL and SRA run on an iterative shifter that
// moves one bit per cycle, so the ALU stalls until hs_cal4al_rdy rises.
//
// Ports:
//   clk            in   core clock
//   rst            in   asynchronous active-high reset
//   hs_al4cal_val  in   request valid; the ALU holds it until ready
//   i_cal_opb      in   op bundle: one-hot flags plus OPN1/OPN2 (33 bits each)
//   hs_cal4al_rdy  out  request completes this cycle
//   o_cal_res      out  32-bit result; 0 whenever hs_cal4al_rdy is low
//
// Op bundle layout, LSB first: ADD, SUB, SLL, SRL, SRA, XOR, CMP flags,
// then OPN1[32:0], then OPN2[32:0].

`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 73
`define CIRNO_CAL_ADD      0
`define CIRNO_CAL_SUB      1
`define CIRNO_CAL_SLL      2
`define CIRNO_CAL_SRL      3
`define CIRNO_CAL_SRA      4
`define CIRNO_CAL_XOR      5
`define CIRNO_CAL_CMP      6
`define CIRNO_CAL_OPN1     39:7
`define CIRNO_CAL_OPN2     72:40
`endif

module exu_cal (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hs_al4cal_val,
  input  logic [`CIRNO_CAL_OPB_SIZE-1:0] i_cal_opb,
  output logic                           hs_cal4al_rdy,
  output logic [31:0]                    o_cal_res
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [32:0] sh_reg, sh_next;
  logic [4:0]  cnt_reg, cnt_next;

  logic        op_add, op_sub, op_sll, op_srl, op_sra, op_xor, op_cmp;
  logic        is_shift;
  logic [32:0] opn_a, opn_b;
  logic [4:0]  shamt;
  logic [33:0] cmp_diff;
  logic [32:0] sh_step;

  assign op_add   = i_cal_opb[`CIRNO_CAL_ADD];
  assign op_sub   = i_cal_opb[`CIRNO_CAL_SUB];
  assign op_sll   = i_cal_opb[`CIRNO_CAL_SLL];
  assign op_srl   = i_cal_opb[`CIRNO_CAL_SRL];
  assign op_sra   = i_cal_opb[`CIRNO_CAL_SRA];
  assign op_xor   = i_cal_opb[`CIRNO_CAL_XOR];
  assign op_cmp   = i_cal_opb[`CIRNO_CAL_CMP];
  assign opn_a    = i_cal_opb[`CIRNO_CAL_OPN1];
  assign opn_b    = i_cal_opb[`CIRNO_CAL_OPN2];
  assign shamt    = opn_b[4:0];
  assign is_shift = op_sll | op_srl | op_sra;

  // Operands are already extended upstream, so the sign of the 34-bit
  // difference gives both signed and unsigned less-than.
  assign cmp_diff = {opn_a[32], opn_a} - {opn_b[32], opn_b};

  // SRL operands arrive zero-extended, so filling from bit 32 makes one
  // arithmetic right shifter serve both SRL and SRA. Direction is taken
  // from the live bundle each cycle; nothing about the op is latched.
  assign sh_step = op_sll ? {sh_reg[31:0], 1'b0} : {sh_reg[32], sh_reg[32:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sh_reg    <= 33'd0;
      cnt_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    cnt_next      = cnt_reg;
    hs_cal4al_rdy = 1'b0;
    o_cal_res     = 32'd0;

    case (state_reg)
      ST_IDLE: begin
        if (hs_al4cal_val) begin
          if (op_add) begin
            hs_cal4al_rdy = 1'b1;
            o_cal_res     = opn_a[31:0] + opn_b[31:0];
          end else if (op_sub) begin
            hs_cal4al_rdy = 1'b1;
            o_cal_res     = opn_a[31:0] - opn_b[31:0];
          end else if (op_xor) begin
            hs_cal4al_rdy = 1'b1;
            o_cal_res     = opn_a[31:0] ^ opn_b[31:0];
          end else if (op_cmp) begin
            hs_cal4al_rdy = 1'b1;
            o_cal_res     = {31'd0, cmp_diff[33]};
          end else if (is_shift) begin
            if (shamt == 5'd0) begin
              hs_cal4al_rdy = 1'b1;
              o_cal_res     = opn_a[31:0];
            end else begin
              sh_next    = opn_a;
              cnt_next   = shamt;
              state_next = ST_BUSY;
            end
          end
        end
      end

      ST_BUSY: begin
        // A dropped val (the ALU zero-gates the bundle) is a flush.
        if (!hs_al4cal_val || !is_shift) begin
          state_next = ST_IDLE;
        end else begin
          sh_next  = sh_step;
          cnt_next = cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        if (hs_al4cal_val && is_shift) begin
          hs_cal4al_rdy = 1'b1;
          o_cal_res     = sh_reg[31:0];
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exu_cal.sv
// Directed testbench for exu_cal. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well away from the edge.

`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 73
`define CIRNO_CAL_ADD      0
`define CIRNO_CAL_SUB      1
`define CIRNO_CAL_SLL      2
`define CIRNO_CAL_SRL      3
`define CIRNO_CAL_SRA      4
`define CIRNO_CAL_XOR      5
`define CIRNO_CAL_CMP      6
`define CIRNO_CAL_OPN1     39:7
`define CIRNO_CAL_OPN2     72:40
`endif

module tb_exu_cal;

  logic                           clk;
  logic                           rst;
  logic                           hs_al4cal_val;
  logic [`CIRNO_CAL_OPB_SIZE-1:0] i_cal_opb;
  logic                           hs_cal4al_rdy;
  logic [31:0]                    o_cal_res;

  int n_checks = 0;
  int n_pass   = 0;

  exu_cal dut (
    .clk           (clk),
    .rst           (rst),
    .hs_al4cal_val (hs_al4cal_val),
    .i_cal_opb     (i_cal_opb),
    .hs_cal4al_rdy (hs_cal4al_rdy),
    .o_cal_res     (o_cal_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [`CIRNO_CAL_OPB_SIZE-1:0] mk_opb(input int flag,
                                                           input logic [32:0] a,
                                                           input logic [32:0] b);
    logic [`CIRNO_CAL_OPB_SIZE-1:0] v;
    v = '0;
    v[flag] = 1'b1;
    v[`CIRNO_CAL_OPN1] = a;
    v[`CIRNO_CAL_OPN2] = b;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s got 0x%08h", tag, obs);
    end else begin
      $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int flag, input logic [32:0] a, input logic [32:0] b);
    hs_al4cal_val = 1'b1;
    i_cal_opb     = mk_opb(flag, a, b);
    #1;
  endtask

  task automatic go_idle();
    hs_al4cal_val = 1'b0;
    i_cal_opb     = '0;
    step();
  endtask

  // Single-cycle op: check same-cycle ready and result.
  task automatic comb_op(input string tag, input int flag, input logic [32:0] a,
                         input logic [32:0] b, input logic [31:0] exp);
    drive(flag, a, b);
    check({tag, "_rdy"}, {31'd0, hs_cal4al_rdy}, 32'd1);
    check({tag, "_res"}, o_cal_res, exp);
    go_idle();
  endtask

  int cyc;
  bit seen_rdy;

  initial begin
    rst           = 1'b1;
    hs_al4cal_val = 1'b0;
    i_cal_opb     = '0;
    #1;
    check("rst_rdy", {31'd0, hs_cal4al_rdy}, 32'd0);
    check("rst_res", o_cal_res, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    comb_op("add", `CIRNO_CAL_ADD, 33'h0_7FFFFFFF, 33'h0_00000001, 32'h80000000);
    comb_op("sub", `CIRNO_CAL_SUB, 33'h0_00000005, 33'h0_00000007, 32'hFFFFFFFE);
    comb_op("cmp_s", `CIRNO_CAL_CMP, 33'h1_FFFFFFFF, 33'h0_00000001, 32'd1);
    comb_op("cmp_u", `CIRNO_CAL_CMP, 33'h0_FFFFFFFF, 33'h0_00000001, 32'd0);
    comb_op("cmp_eq", `CIRNO_CAL_CMP, 33'h0_12345678, 33'h0_12345678, 32'd0);
    comb_op("cmp_ult", `CIRNO_CAL_CMP, 33'h0_00000003, 33'h0_80000000, 32'd1);
    comb_op("xor", `CIRNO_CAL_XOR, 33'h0_A5A5A5A5, 33'h0_0F0F0F0F, 32'hAAAAAAAA);

    // val with no op flag: nothing completes.
    hs_al4cal_val = 1'b1;
    i_cal_opb     = '0;
    #1;
    check("noop_rdy", {31'd0, hs_cal4al_rdy}, 32'd0);
    check("noop_res", o_cal_res, 32'd0);
    go_idle();

    // SRA by 4: ready low on cycles 0..4, high on 5, back in IDLE on 6.
    drive(`CIRNO_CAL_SRA, 33'h1_80000000, 33'h0_00000004);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sra_wait%0d", i), {31'd0, hs_cal4al_rdy}, 32'd0);
      if (i < 4) step();
    end
    check("sra_wait_res", o_cal_res, 32'd0);
    step();
    check("sra_rdy", {31'd0, hs_cal4al_rdy}, 32'd1);
    check("sra_res", o_cal_res, 32'hF8000000);
    step();
    check("sra_idle_rdy", {31'd0, hs_cal4al_rdy}, 32'd0);
    go_idle();

    // SRL by 31: maximum latency, ready on cycle 32.
    drive(`CIRNO_CAL_SRL, 33'h0_80000000, 33'h0_0000001F);
    cyc = 0;
    while (!hs_cal4al_rdy && cyc < 40) begin
      step();
      cyc++;
    end
    check("srl_lat", cyc, 32'd32);
    check("srl_res", o_cal_res, 32'h00000001);
    go_idle();

    // SLL by 5: direction and zero fill.
    drive(`CIRNO_CAL_SLL, 33'h0_80000001, 33'h0_00000005);
    cyc = 0;
    while (!hs_cal4al_rdy && cyc < 40) begin
      step();
      cyc++;
    end
    check("sll5_lat", cyc, 32'd6);
    check("sll5_res", o_cal_res, 32'h00000020);
    go_idle();

    comb_op("sll0", `CIRNO_CAL_SLL, 33'h0_00000001, 33'h0_00000000, 32'd1);

    // Abort: SLL by 8, val dropped on cycle 3, XOR accepted on cycle 4.
    drive(`CIRNO_CAL_SLL, 33'h0_00000001, 33'h0_00000008);
    seen_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (hs_cal4al_rdy) seen_rdy = 1'b1;
      step();
    end
    hs_al4cal_val = 1'b0;
    i_cal_opb     = '0;
    #1;
    if (hs_cal4al_rdy) seen_rdy = 1'b1;
    check("abort_no_rdy", {31'd0, seen_rdy}, 32'd0);
    step();
    comb_op("abort_xor", `CIRNO_CAL_XOR, 33'h0_000000F0, 33'h0_000000FF, 32'h0000000F);

    // Reset during BUSY, with a shift that would otherwise be finishing.
    drive(`CIRNO_CAL_SRL, 33'h0_FFFFFFFF, 33'h0_00000002);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_rdy", {31'd0, hs_cal4al_rdy}, 32'd0);
    check("rstmid_res", o_cal_res, 32'd0);
    hs_al4cal_val = 1'b0;
    i_cal_opb     = '0;
    step();
    rst = 1'b0;
    step();
    comb_op("post_rst_add", `CIRNO_CAL_ADD, 33'h0_00000002, 33'h0_00000003, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
